// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle between the issue stage and the RV32M multiply/divide unit.
interface rv32m_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, operand_a, operand_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, operand_a, operand_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign correction and special cases resolved in a single FIX cycle.
module rv32m_muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input logic          clk,
    input logic          rst_n,
    rv32m_muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(ITER);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        fn_q, fn_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rd_out_q, rd_out_d;
    // Multiply: {product_hi, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiplicand magnitude or divisor magnitude.
    logic [XLEN-1:0]   op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;

    logic              in_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Decode signedness of the incoming request and form operand magnitudes.
    always_comb begin
        in_div   = bus.funct3[2];
        a_signed = in_div ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
        b_signed = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg    = a_signed & bus.operand_a[XLEN-1];
        b_neg    = b_signed & bus.operand_b[XLEN-1];
        a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
        b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
    end

    // One iteration step for both datapaths, plus the sign-corrected FIX result.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        // rem_sh < 2*divisor, so bit XLEN of the difference is a clean borrow flag.
        div_diff = rem_sh - {1'b0, op_q};
        div_ge   = ~div_diff[XLEN];
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        // Overflow (MIN / -1) falls out naturally; divide by zero overrides the quotient.
        // A zero divisor leaves |dividend| as remainder, so REM by zero yields operand_a.
        case (fn_q)
            3'b000:          fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fix_res = (op_q == '0) ? '1 : quo_fix;
            default:         fix_res = rem_fix;
        endcase
    end

    // Next-state and datapath update for the IDLE/ITER/FIX/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fn_d      = fn_q;
        rd_d      = rd_q;
        rd_out_d  = rd_out_q;
        acc_d     = acc_q;
        op_d      = op_q;
        result_d  = result_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.kill) begin
                    state_d   = StIter;
                    cnt_d     = CntW'(ITER - 1);
                    fn_d      = bus.funct3;
                    rd_d      = bus.rd_in;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (in_div) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        op_d  = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        op_d  = a_mag;
                    end
                end
            end
            StIter: begin
                if (bus.kill) begin
                    state_d = StIdle;
                end else begin
                    if (fn_q[2]) begin
                        acc_d = {div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0],
                                 acc_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (bus.kill) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_res;
                    rd_out_d = rd_q;
                    state_d  = StDone;
                end
            end
            StDone: begin
                // The write is already committed; kill has no effect here.
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fn_q      <= '0;
            rd_q      <= '0;
            rd_out_q  <= '0;
            acc_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fn_q      <= fn_d;
            rd_q      <= rd_d;
            rd_out_q  <= rd_out_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed and random RV32M ops against an
// arithmetic reference model, plus kill, held-start and asynchronous reset scenarios.
module tb_rv32m_muldiv_unit;
    logic clk;
    logic rst_n;

    rv32m_muldiv_if #(.XLEN(32)) bus ();

    rv32m_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_cnt = 0;
    logic [36:0] sb_q[$];
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model written directly from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, ub;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 required=0 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("result", bus.result, e[36:5]);
                check("rd_out", 32'(bus.rd_out), 32'(e[4:0]));
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.funct3    = f;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in     = rd;
    endtask

    task automatic expect_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        last_res = model(f, a, b);
        last_rd  = rd;
        sb_q.push_back({last_res, rd});
    endtask

    // Wait (bounded) for done sampled #1 after an edge; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Issue one op from IDLE and check acceptance, latency and the return to IDLE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit kill_in_done);
        int n;
        @(negedge clk);
        drive(f, a, b, rd);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        expect_op(f, a, b, rd);
        // Scramble inputs to show they are not re-sampled.
        drive(3'(~f), ~a, ~b, ~rd);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("done_latency", 32'(n), 32'd33);
        if (kill_in_done) bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int unsigned dc;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        drive(3'd0, '0, '0, '0);
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(3'd0, 32'd7, 32'd6, 5'd9, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd1, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd2, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
        run_op(3'd4, -32'sd7, 32'd2, 5'd4, 1'b0);
        run_op(3'd6, -32'sd7, 32'd2, 5'd5, 1'b0);
        run_op(3'd5, 32'd7, 32'd2, 5'd6, 1'b0);
        run_op(3'd7, 32'd7, 32'd2, 5'd7, 1'b0);
        for (int f = 4; f < 8; f++) run_op(3'(f), 32'h1234_5678, 32'h0, 5'(f + 10), 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd21, 1'b1);

        // Kill ten edges into ITER: no done, outputs keep the previous result.
        @(negedge clk);
        drive(3'd0, 32'd123, 32'd456, 5'd30);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill_busy", 32'(bus.busy), 32'd0);
        check("kill_result_held", bus.result, last_res);
        check("kill_rd_held", 32'(bus.rd_out), 32'(last_rd));
        dc = done_cnt;
        repeat (40) @(posedge clk);
        check("kill_no_done", done_cnt - dc, 32'd0);

        // start held through a whole op: the second op is accepted only after IDLE.
        @(negedge clk);
        drive(3'd0, 32'd7, 32'd6, 5'd11);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        expect_op(3'd0, 32'd7, 32'd6, 5'd11);
        drive(3'd5, 32'd100, 32'd3, 5'd12);
        wait_done(n);
        check("held_latency", 32'(n), 32'd33);
        @(posedge clk);
        #1;
        check("held_idle_gap", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("held_second_accept", 32'(bus.busy), 32'd1);
        expect_op(3'd5, 32'd100, 32'd3, 5'd12);
        wait_done(n);
        check("held_second_latency", 32'(n), 32'd33);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-ITER.
        @(negedge clk);
        drive(3'd4, 32'd1000, 32'd7, 5'd15);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        last_rd  = '0;
        dc = done_cnt;
        repeat (40) @(posedge clk);
        check("arst_no_done", done_cnt - dc, 32'd0);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'b0);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file. It takes the two read-port values (rs1, rs2) plus the destination register number.
- Produces a 32-bit result with a write-enable pulse and destination index, ready for the register-file write port (WriteRegister/RegWrite/WriteData).
- Fixed multi-cycle latency. The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration cycles per operation; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- kill  input  1  synchronous abort of an in-flight operation (pipeline flush)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  input  32  rs1 value
- operand_b  input  32  rs2 value
- rd_in  input  5  destination register
- busy  output  1  high while an operation is accepted and not yet done
- done  output  1  one-cycle result-valid pulse; drives the register-file write enable
- result  output  32  registered result
- rd_out  output  5  registered destination register

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
  - All internal operand/accumulator registers are cleared.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - On an edge with start=1 and kill=0, latch funct3, rd_in, and the operand magnitudes (signedness per funct3), plus the result-sign flags.
  - Counter is loaded with 31; next state is ITER; busy=1 from that edge.
  - start=0, or start=1 with kill=1: remain in IDLE.
- ITER:
  - Multiply: one radix-2 shift-add step per edge into a 64-bit product register.
  - Divide: one restoring step per edge (shift in dividend bit, trial-subtract divisor, set quotient bit).
  - Counter decrements each edge; at counter=0 the next state is FIX.
  - Exactly 32 edges are spent in ITER.
- FIX: one edge. Apply sign correction and select the result:
  - MUL: low 32 bits of the product.
  - MULH / MULHSU / MULHU: high 32 bits (signed×signed, signed×unsigned, unsigned×unsigned).
  - DIV/DIVU: quotient. REM/REMU: remainder. Remainder sign follows the dividend.
  - Register the result into result and rd_out; next state is DONE.
- DONE: done=1 and busy=1 for exactly one cycle; next edge goes to IDLE with busy=0, done=0.
- result and rd_out hold their value until the next FIX.
- Latency: accept edge E0; done is high in the cycle following edge E0+33; busy is high for 34 cycles. The latency is the same for every funct3 and every operand value.
- Special cases: computed in FIX, with the same latency.
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return operand_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- start while busy=1: ignored. Operand inputs are not re-sampled.
- kill=1 in ITER or FIX: next edge goes to IDLE with busy=0.
  - No done pulse is produced, and result/rd_out are left unchanged.
- kill=1 in DONE: done still completes its single cycle (the write is already committed).
- rd_in=0: the operation executes normally and rd_out=0; x0 protection is the register file's job.
- rst_n asserted mid-operation: everything returns immediately to the reset values, with no done pulse.

Test Plan:
- Reset then MUL, a=7, b=6 -> done pulse exactly 34 cycles after the accept edge; result=0x0000002A, rd_out=rd_in; busy high for 34 cycles.
- MULH a=0xFFFFFFFF (-1), b=0x00000002 -> result=0xFFFFFFFF; MULHU with the same operands -> 0x00000001; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU a=7, b=2 -> 3; REMU -> 1.
- DIV/REM by zero with a=0x12345678 -> DIV 0xFFFFFFFF, DIVU 0xFFFFFFFF, REM/REMU 0x12345678; latency still 34.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; no hang.
- Abort and reset:
  - kill asserted at cycle 10 of ITER -> busy drops next edge, no done, result keeps its prior value.
  - start held during busy -> a second operation starts only after return to IDLE.
  - rst_n pulsed mid-ITER -> all outputs go to 0 asynchronously.
